// File: rtl/ik_sched_ctrl.sv
// Schedule controller for the IK solver datapath: per-iteration cycle counter
// plus window-based arbitration of a shared multiplier bank with latency-aligned result routing.
module ik_sched_ctrl #(
    parameter int CW        = 8,
    parameter int IW        = 8,
    parameter int NCLI      = 2,
    parameter int LANES     = 9,
    parameter int DW        = 27,
    parameter int MULT_LAT  = 4,
    parameter int RST_DELAY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     start,
    input  logic                     abort,
    input  logic [CW-1:0]            period,
    input  logic [IW-1:0]            iters,
    input  logic [NCLI*CW-1:0]       win_lo,
    input  logic [NCLI*CW-1:0]       win_hi,
    input  logic [NCLI-1:0]          cli_mode,
    input  logic [NCLI*LANES*DW-1:0] cli_dataa,
    input  logic [NCLI*LANES*DW-1:0] cli_datab,
    input  logic [LANES*DW-1:0]      mult_result,
    output logic [CW-1:0]            count,
    output logic [IW-1:0]            iter,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err,
    output logic                     ovl_err,
    output logic [NCLI-1:0]          grant,
    output logic                     mult_rst,
    output logic                     mult_mode,
    output logic [LANES*DW-1:0]      mult_dataa,
    output logic [LANES*DW-1:0]      mult_datab,
    output logic [LANES*DW-1:0]      cli_result,
    output logic [NCLI-1:0]          cli_valid
);

    localparam int OW = LANES * DW;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]                   state;
    logic [CW-1:0]                per_q;
    logic [IW-1:0]                its_q;
    logic                         run;
    logic                         flush;
    logic                         found;
    logic                         multi;
    logic                         rst_src;
    logic [MULT_LAT-1:0][NCLI-1:0] gpipe;

    assign run        = (state == RUN);
    assign flush      = run && abort;
    assign busy       = run;
    assign done       = (state == DONE);
    assign cli_result = mult_result;
    assign cli_valid  = gpipe[MULT_LAT-1] & {NCLI{en}};

    // Lowest-index matching window owns the bank; further matches only flag overlap.
    always_comb begin
        grant      = '0;
        found      = 1'b0;
        multi      = 1'b0;
        rst_src    = 1'b0;
        mult_mode  = 1'b1;
        mult_dataa = '0;
        mult_datab = '0;
        for (int unsigned k = 0; k < NCLI; k++) begin
            if (run && count >= win_lo[k*CW +: CW] && count < win_hi[k*CW +: CW]) begin
                if (found) begin
                    multi = 1'b1;
                end else begin
                    found      = 1'b1;
                    grant[k]   = 1'b1;
                    mult_mode  = cli_mode[k];
                    mult_dataa = cli_dataa[k*OW +: OW];
                    mult_datab = cli_datab[k*OW +: OW];
                end
            end
            if (run && en && count == win_lo[k*CW +: CW])
                rst_src = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            iter    <= '0;
            per_q   <= '0;
            its_q   <= '0;
            cfg_err <= 1'b0;
            ovl_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (flush) begin
                state <= IDLE;
                count <= '0;
                iter  <= '0;
            end else if (en) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (period == '0 || iters == '0) begin
                                cfg_err <= 1'b1;
                            end else begin
                                per_q <= period;
                                its_q <= iters;
                                count <= '0;
                                iter  <= '0;
                                state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (count == per_q - 1'b1) begin
                            count <= '0;
                            if (iter == its_q - 1'b1)
                                state <= DONE;
                            else
                                iter <= iter + 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
                if (multi)
                    ovl_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpipe <= '0;
        end else if (flush) begin
            gpipe <= '0;
        end else if (en) begin
            gpipe[0] <= grant;
            for (int unsigned i = 1; i < MULT_LAT; i++)
                gpipe[i] <= gpipe[i-1];
        end
    end

    generate
        if (RST_DELAY == 0) begin : g_rst_comb
            assign mult_rst = rst_src;
        end else begin : g_rst_pipe
            logic [RST_DELAY-1:0] rpipe;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rpipe <= '0;
                end else if (flush) begin
                    rpipe <= '0;
                end else if (en) begin
                    rpipe[0] <= rst_src;
                    for (int unsigned i = 1; i < RST_DELAY; i++)
                        rpipe[i] <= rpipe[i-1];
                end
            end
            assign mult_rst = rpipe[RST_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_ik_sched_ctrl.sv
// Scoreboard bench for ik_sched_ctrl: a run-time based reference model predicts each cycle,
// a negedge monitor pops predictions and compares against the DUT.
module tb_ik_sched_ctrl;

    localparam int CW = 8, IW = 8, NCLI = 2, LANES = 9, DW = 27, MULT_LAT = 4, RST_DELAY = 1;
    localparam int OW = LANES * DW;

    logic                clk = 1'b0, rst = 1'b0, en = 1'b0, start = 1'b0, abort = 1'b0;
    logic [CW-1:0]       period = '0;
    logic [IW-1:0]       iters = '0;
    logic [NCLI*CW-1:0]  win_lo = '0, win_hi = '0;
    logic [NCLI-1:0]     cli_mode = '0;
    logic [NCLI*OW-1:0]  cli_dataa = '0, cli_datab = '0;
    logic [OW-1:0]       mult_result = '0;
    logic [CW-1:0]       count;
    logic [IW-1:0]       iter;
    logic                busy, done, cfg_err, ovl_err, mult_rst, mult_mode;
    logic [NCLI-1:0]     grant, cli_valid;
    logic [OW-1:0]       mult_dataa, mult_datab, cli_result;

    ik_sched_ctrl #(.CW(CW), .IW(IW), .NCLI(NCLI), .LANES(LANES), .DW(DW),
                    .MULT_LAT(MULT_LAT), .RST_DELAY(RST_DELAY)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .abort(abort),
        .period(period), .iters(iters), .win_lo(win_lo), .win_hi(win_hi),
        .cli_mode(cli_mode), .cli_dataa(cli_dataa), .cli_datab(cli_datab),
        .mult_result(mult_result), .count(count), .iter(iter), .busy(busy),
        .done(done), .cfg_err(cfg_err), .ovl_err(ovl_err), .grant(grant),
        .mult_rst(mult_rst), .mult_mode(mult_mode), .mult_dataa(mult_dataa),
        .mult_datab(mult_datab), .cli_result(cli_result), .cli_valid(cli_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    typedef struct {
        int            cyc;
        int            count;
        int            iter;
        logic          busy;
        logic [NCLI-1:0] grant;
        logic          mode;
        logic [OW-1:0] a, b, res;
        logic          ovl;
    } status_t;

    typedef struct {
        int              cyc;
        logic [NCLI-1:0] vec;
    } ev_t;

    status_t sq[$];
    ev_t     evq[4][$];   // 0 done, 1 cfg_err, 2 mult_rst, 3 cli_valid

    // Reference model: a run is "t enabled RUN cycles elapsed"; count/iter follow by div/mod.
    bit              m_run, m_done, m_cfg, m_ovl;
    int              m_t, m_per, m_its, d_count, d_iter;
    bit [NCLI-1:0]   gh[$];
    bit              rh[$];
    bit [NCLI-1:0]   cur_g;
    bit              cur_r, cur_multi;
    logic [NCLI*CW-1:0] pend_lo = '0, pend_hi = '0;

    function automatic void chk(string n, logic [OW-1:0] act, logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", n, cyc, act, exp);
        end
    endfunction

    function automatic void flush_hist();
        gh.delete();
        rh.delete();
        for (int i = 0; i < MULT_LAT; i++) gh.push_back('0);
        for (int i = 0; i < RST_DELAY; i++) rh.push_back(1'b0);
    endfunction

    function automatic void model_reset();
        m_run = 0; m_done = 0; m_cfg = 0; m_ovl = 0;
        m_t = 0; m_per = 1; m_its = 1; d_count = 0; d_iter = 0;
        flush_hist();
    endfunction

    function automatic int wlo(int k); return int'(win_lo[k*CW +: CW]); endfunction
    function automatic int whi(int k); return int'(win_hi[k*CW +: CW]); endfunction

    // Advance the model over the clock edge that sampled the currently held inputs.
    function automatic void step();
        m_cfg = 0;
        if (m_run && abort) begin
            m_run = 0; d_count = 0; d_iter = 0;
            flush_hist();
        end else if (en) begin
            void'(gh.pop_front()); gh.push_back(cur_g);
            void'(rh.pop_front()); rh.push_back(cur_r);
            if (cur_multi) m_ovl = 1;
            if (m_done) begin
                m_done = 0;
            end else if (m_run) begin
                m_t++;
                if (m_t == m_per * m_its) begin
                    m_run = 0; m_done = 1; d_count = 0; d_iter = m_its - 1;
                end
            end else if (start) begin
                if (period == 0 || iters == 0) m_cfg = 1;
                else begin
                    m_run = 1; m_t = 0; m_per = int'(period); m_its = int'(iters);
                end
            end
        end
    endfunction

    function automatic void predict();
        status_t s;
        ev_t     e;
        int      c, nm, gk;
        c  = m_run ? m_t % m_per : d_count;
        nm = 0; gk = -1; cur_g = '0; cur_r = 0;
        if (m_run) begin
            for (int k = 0; k < NCLI; k++) begin
                if (wlo(k) <= c && c < whi(k)) begin
                    if (nm == 0) begin cur_g[k] = 1'b1; gk = k; end
                    nm++;
                end
                if (c == wlo(k) && en) cur_r = 1;
            end
        end
        cur_multi = (nm > 1);
        s.cyc = cyc; s.count = c; s.iter = m_run ? m_t / m_per : d_iter;
        s.busy = m_run; s.grant = cur_g; s.ovl = m_ovl; s.res = mult_result;
        s.mode = (gk < 0) ? 1'b1 : cli_mode[gk];
        s.a = (gk < 0) ? '0 : cli_dataa[gk*OW +: OW];
        s.b = (gk < 0) ? '0 : cli_datab[gk*OW +: OW];
        sq.push_back(s);
        e.cyc = cyc;
        if (m_done) begin e.vec = 1; evq[0].push_back(e); end
        if (m_cfg)  begin e.vec = 1; evq[1].push_back(e); end
        if (rh[0])  begin e.vec = 1; evq[2].push_back(e); end
        if ((gh[0] & {NCLI{en}}) != 0) begin e.vec = gh[0] & {NCLI{en}}; evq[3].push_back(e); end
    endfunction

    function automatic void check_ev(int i, string n, logic [NCLI-1:0] act);
        logic [NCLI-1:0] exp;
        ev_t e;
        exp = '0;
        while (evq[i].size() > 0 && evq[i][0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL %s stale cyc=%0d act=%0h exp_at_cyc=%0d", n, cyc, act, evq[i][0].cyc);
            void'(evq[i].pop_front());
        end
        if (evq[i].size() > 0 && evq[i][0].cyc == cyc) begin
            e = evq[i].pop_front();
            exp = e.vec;
        end
        chk(n, act, exp);
    endfunction

    always @(negedge clk) begin
        status_t s;
        if (!rst) begin
            while (sq.size() > 0 && sq[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL status stale cyc=%0d act=none exp_at_cyc=%0d", cyc, sq[0].cyc);
                void'(sq.pop_front());
            end
            if (sq.size() > 0 && sq[0].cyc == cyc) begin
                s = sq.pop_front();
                chk("count", count, s.count[CW-1:0]);
                chk("iter", iter, s.iter[IW-1:0]);
                chk("busy", busy, s.busy);
                chk("grant", grant, s.grant);
                chk("mult_mode", mult_mode, s.mode);
                chk("mult_dataa", mult_dataa, s.a);
                chk("mult_datab", mult_datab, s.b);
                chk("cli_result", cli_result, s.res);
                chk("ovl_err", ovl_err, s.ovl);
            end
            check_ev(0, "done", done);
            check_ev(1, "cfg_err", cfg_err);
            check_ev(2, "mult_rst", mult_rst);
            check_ev(3, "cli_valid", cli_valid);
        end
    end

    task automatic set_win(input int l0, input int h0, input int l1, input int h1);
        logic [CW-1:0] v;
        v = l0[CW-1:0]; pend_lo[0 +: CW] = v;
        v = h0[CW-1:0]; pend_hi[0 +: CW] = v;
        v = l1[CW-1:0]; pend_lo[CW +: CW] = v;
        v = h1[CW-1:0]; pend_hi[CW +: CW] = v;
    endtask

    task automatic cyc_drive(input bit e, input bit s, input bit a, input int p, input int n);
        @(posedge clk);
        #1;
        step();
        en = e; start = s; abort = a;
        period = p[CW-1:0]; iters = n[IW-1:0];
        win_lo = pend_lo; win_hi = pend_hi;
        for (int i = 0; i < NCLI; i++) cli_mode[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < NCLI * OW; i++) begin
            cli_dataa[i] = 1'($urandom_range(0, 1));
            cli_datab[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < OW; i++) mult_result[i] = 1'($urandom_range(0, 1));
        predict();
    endtask

    task automatic reset_seq();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_count", count, '0);
        chk("rst_iter", iter, '0);
        chk("rst_busy", busy, '0);
        chk("rst_done", done, '0);
        chk("rst_cfg_err", cfg_err, '0);
        chk("rst_ovl_err", ovl_err, '0);
        chk("rst_grant", grant, '0);
        chk("rst_mult_rst", mult_rst, '0);
        chk("rst_cli_valid", cli_valid, '0);
        chk("rst_mult_dataa", mult_dataa, '0);
        chk("rst_mult_datab", mult_datab, '0);
        sq.delete();
        for (int i = 0; i < 4; i++) evq[i].delete();
        model_reset();
        en = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        predict();
    endtask

    initial begin
        reset_seq();

        // Basic run with disjoint windows.
        set_win(2, 5, 5, 9);
        cyc_drive(1, 1, 0, 10, 3);
        repeat (40) cyc_drive(1, 0, 0, 10, 3);

        // Rejected start, then a one-iteration run.
        cyc_drive(1, 1, 0, 0, 3);
        cyc_drive(1, 0, 0, 0, 3);
        cyc_drive(1, 1, 0, 5, 1);
        repeat (8) cyc_drive(1, 0, 0, 5, 1);

        // Overlapping windows.
        set_win(2, 6, 4, 8);
        cyc_drive(1, 1, 0, 10, 1);
        repeat (14) cyc_drive(1, 0, 0, 10, 1);

        // Enable held low for three cycles at count 6.
        set_win(2, 5, 5, 9);
        cyc_drive(1, 1, 0, 10, 2);
        for (int i = 0; i < 50 && !(m_run && m_t == 5); i++) cyc_drive(1, 0, 0, 10, 2);
        repeat (3) cyc_drive(0, 0, 0, 10, 2);
        repeat (25) cyc_drive(1, 0, 0, 10, 2);

        // Abort at count 7 of iteration 1.
        cyc_drive(1, 1, 0, 10, 3);
        for (int i = 0; i < 50 && !(m_run && m_t == 16); i++) cyc_drive(1, 0, 0, 10, 3);
        cyc_drive(1, 0, 1, 10, 3);
        repeat (8) cyc_drive(1, 0, 0, 10, 3);

        // Asynchronous reset mid-run.
        cyc_drive(1, 1, 0, 10, 3);
        repeat (12) cyc_drive(1, 0, 0, 10, 3);
        reset_seq();

        // Randomised traffic, including empty and overlapping windows.
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0)
                set_win($urandom_range(0, 12), $urandom_range(0, 12),
                        $urandom_range(0, 12), $urandom_range(0, 12));
            if (i == 1500) reset_seq();
            cyc_drive($urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 79) == 0, $urandom_range(0, 12), $urandom_range(0, 3));
        end

        repeat (10) cyc_drive(1, 0, 0, 1, 1);
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            while (evq[i].size() > 0 && evq[i][0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL event_never_seen kind=%0d act=none exp_at_cyc=%0d", i, evq[i][0].cyc);
                void'(evq[i].pop_front());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
